// File: rtl/ssd_block_streamer.sv
// ssd_block_streamer
//   Producer for the calculate_ssd input interface. On start it walks one
//   BLOCK_SIZE x BLOCK_SIZE template block and one candidate block (raster
//   order, x inner) out of two read-only frame BRAM ports and streams aligned
//   {tmpl,cand,last} pairs downstream with valid/ready handshaking.
//
//   BRAM latency is hidden by a tag pipe that runs alongside the BRAM. Reads
//   are only issued while (fifo occupancy + reads in flight) < FIFO_DEPTH.
//   Because of that credit rule, every issued read already owns a FIFO slot,
//   so the skid FIFO can never overflow under backpressure.
//
//   Optional feature: define SSD_STREAMER_CLAMP_EN to clamp pixel coordinates
//   to the frame edge (edge replication for blocks that overhang the frame).
//
// Ports
//   clk_in, rst_in              clock, async active-high reset
//   start_in                    start pulse (ignored while busy_out)
//   tmpl_x_in/tmpl_y_in         template block origin (captured on start)
//   cand_x_in/cand_y_in         candidate block origin (captured on start)
//   tmpl_addr_out/tmpl_data_in  template BRAM read port
//   cand_addr_out/cand_data_in  candidate BRAM read port
//   pair_valid_out/pair_ready_in, tmpl_pix_out, cand_pix_out, pair_last_out
//                               pair stream to calculate_ssd
//   busy_out                    block in progress
//   done_out                    1-cycle pulse after the last pair is accepted
module ssd_block_streamer #(
  parameter int BLOCK_SIZE   = 8,
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int PIXEL_W      = 8,
  parameter int ADDR_W       = 17,
  parameter int BRAM_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [8:0]         tmpl_x_in,
  input  logic [7:0]         tmpl_y_in,
  input  logic [8:0]         cand_x_in,
  input  logic [7:0]         cand_y_in,
  output logic [ADDR_W-1:0]  tmpl_addr_out,
  input  logic [PIXEL_W-1:0] tmpl_data_in,
  output logic [ADDR_W-1:0]  cand_addr_out,
  input  logic [PIXEL_W-1:0] cand_data_in,
  output logic               pair_valid_out,
  input  logic               pair_ready_in,
  output logic [PIXEL_W-1:0] tmpl_pix_out,
  output logic [PIXEL_W-1:0] cand_pix_out,
  output logic               pair_last_out,
  output logic               busy_out,
  output logic               done_out
);

  localparam int FIFO_DEPTH = BRAM_LATENCY + 2;
  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [PIXEL_W-1:0] tmpl;
    logic [PIXEL_W-1:0] cand;
    logic               last;
  } pair_t;

  state_t             state_q, state_d;
  logic [8:0]         tx_q, tx_d, cx_q, cx_d;
  logic [7:0]         ty_q, ty_d, cy_q, cy_d;
  logic [CW-1:0]      bx_q, bx_d, by_q, by_d;
  logic [BRAM_LATENCY:1] vld_pipe_q, vld_pipe_d;
  logic [BRAM_LATENCY:1] last_pipe_q, last_pipe_d;
  pair_t              mem_q [FIFO_DEPTH];
  pair_t              mem_d [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]      cnt_q, cnt_d;

  logic               issue, last_rd, push, pop;
  logic [NW:0]        inflight, occupancy;
  pair_t              head, push_data;

  // Pixel coordinate -> linear frame address, optionally clamped to the frame.
  function automatic logic [ADDR_W-1:0] pix_addr(logic [9:0] px, logic [8:0] py);
    logic [9:0] x;
    logic [8:0] y;
    x = px;
    y = py;
`ifdef SSD_STREAMER_CLAMP_EN
    if (x > 10'(IMG_WIDTH - 1))  x = 10'(IMG_WIDTH - 1);
    if (y > 9'(IMG_HEIGHT - 1))  y = 9'(IMG_HEIGHT - 1);
`endif
    return ADDR_W'(y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Both ports share bx/by so template and candidate pixels stay aligned.
  assign tmpl_addr_out = pix_addr({1'b0, tx_q} + 10'(bx_q), {1'b0, ty_q} + 9'(by_q));
  assign cand_addr_out = pix_addr({1'b0, cx_q} + 10'(bx_q), {1'b0, cy_q} + 9'(by_q));

  assign head           = mem_q[rd_ptr_q];
  assign pair_valid_out = (cnt_q != '0);
  assign tmpl_pix_out   = head.tmpl;
  assign cand_pix_out   = head.cand;
  assign pair_last_out  = head.last;
  assign busy_out       = (state_q != IDLE);
  assign done_out       = (state_q == DONE);

  // Tag pipe output lines up with BRAM data of the same read.
  assign push      = vld_pipe_q[BRAM_LATENCY];
  assign push_data = '{tmpl: tmpl_data_in, cand: cand_data_in, last: last_pipe_q[BRAM_LATENCY]};
  assign pop       = pair_valid_out & pair_ready_in;

  // Credit check: a pair pushed this cycle is still counted as in flight and
  // a pair popped this cycle is still counted in the FIFO, so this is safe.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= BRAM_LATENCY; i++)
      inflight = inflight + (NW + 1)'(vld_pipe_q[i]);
    occupancy = {1'b0, cnt_q} + inflight;
  end

  assign last_rd = (bx_q == CW'(BLOCK_SIZE - 1)) && (by_q == CW'(BLOCK_SIZE - 1));
  assign issue   = (state_q == ISSUE) && (occupancy < (NW + 1)'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    bx_d        = bx_q;
    by_d        = by_q;
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          tx_d    = tmpl_x_in;
          ty_d    = tmpl_y_in;
          cx_d    = cand_x_in;
          cy_d    = cand_y_in;
          bx_d    = '0;
          by_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (bx_q == CW'(BLOCK_SIZE - 1)) begin
            bx_d = '0;
            if (by_q == CW'(BLOCK_SIZE - 1)) state_d = DRAIN;
            else                            by_d = by_q + 1'b1;
          end else begin
            bx_d = bx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    vld_pipe_d[1]  = issue;
    last_pipe_d[1] = issue && last_rd;
    for (int i = 2; i <= BRAM_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      ty_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ssd_block_streamer.sv
// Bench for ssd_block_streamer: BRAM models (pixel = addr[7:0] / ~addr[7:0]),
// a queue of expected pairs computed from the block geometry, and one compare
// process that checks every accepted pair and hold-while-stalled behaviour.
module tb_ssd_block_streamer;
  localparam int BS = 8, W = 320, H = 240, L = 2, NP = BS * BS;
  localparam int DONE_LAT = NP + L + 2;

  logic        clk_in = 1'b0;
  logic        rst_in, start_in, pair_ready_in;
  logic [8:0]  tmpl_x_in, cand_x_in;
  logic [7:0]  tmpl_y_in, cand_y_in;
  logic [16:0] tmpl_addr_out, cand_addr_out;
  logic [7:0]  tmpl_data_in, cand_data_in, tmpl_pix_out, cand_pix_out;
  logic        pair_valid_out, pair_last_out, busy_out, done_out;

  ssd_block_streamer #(.BLOCK_SIZE(BS), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                       .PIXEL_W(8), .ADDR_W(17), .BRAM_LATENCY(L)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .tmpl_x_in(tmpl_x_in), .tmpl_y_in(tmpl_y_in),
    .cand_x_in(cand_x_in), .cand_y_in(cand_y_in),
    .tmpl_addr_out(tmpl_addr_out), .tmpl_data_in(tmpl_data_in),
    .cand_addr_out(cand_addr_out), .cand_data_in(cand_data_in),
    .pair_valid_out(pair_valid_out), .pair_ready_in(pair_ready_in),
    .tmpl_pix_out(tmpl_pix_out), .cand_pix_out(cand_pix_out),
    .pair_last_out(pair_last_out), .busy_out(busy_out), .done_out(done_out));

  always #5 clk_in = ~clk_in;

  // BRAM models: data appears L cycles after the address is presented.
  logic [16:0] ta1, ta2, ca1, ca2;
  always @(posedge clk_in) begin
    ta1 <= tmpl_addr_out; ta2 <= ta1;
    ca1 <= cand_addr_out; ca2 <= ca1;
  end
  assign tmpl_data_in = ta2[7:0];
  assign cand_data_in = ~ca2[7:0];

  typedef struct packed {logic [7:0] t; logic [7:0] c; logic l;} pair_t;

  int    errors = 0, checks = 0, cyc = 0, start_cyc = 0, rcv = 0, rdy_mode = 0;
  bit    skip_vals = 0, first_seen = 0, pstall = 0;
  pair_t exp_q[$];
  pair_t first_got, last_got, pheld, got, e;

  initial forever begin @(posedge clk_in); cyc++; end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference geometry: pixel i of a block at (x0,y0).
  function automatic logic [16:0] pix_addr(int x0, int y0, int i);
    int x, y;
    x = x0 + i % BS;
    y = y0 + i / BS;
`ifdef SSD_STREAMER_CLAMP_EN
    if (x > W - 1) x = W - 1;
    if (y > H - 1) y = H - 1;
`endif
    return 17'(y * W + x);
  endfunction

  task automatic load_exp(int tx, int ty, int cx, int cy);
    logic [16:0] a, b;
    pair_t p;
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      a = pix_addr(tx, ty, i);
      b = pix_addr(cx, cy, i);
      p.t = a[7:0];
      p.c = ~b[7:0];
      p.l = (i == NP - 1);
      exp_q.push_back(p);
    end
  endtask

  // Downstream ready driver.
  initial begin
    pair_ready_in = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      case (rdy_mode)
        0:       pair_ready_in = 1'b1;
        1:       pair_ready_in = 1'($urandom_range(0, 1));
        default: pair_ready_in = 1'b0;
      endcase
    end
  end

  // Compare process: every accepted pair against the expected queue, and
  // stalled outputs must hold.
  initial forever begin
    @(negedge clk_in);
    if (rst_in) begin
      pstall = 0;
    end else begin
      got = {tmpl_pix_out, cand_pix_out, pair_last_out};
      if (pstall) begin
        chk("hold_valid", 32'(pair_valid_out), 32'd1);
        chk("hold_data", 32'(got), 32'(pheld));
      end
      if (pair_valid_out && pair_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_pair: got %0h expected none (cycle %0d)", got, cyc);
        end else begin
          e = exp_q.pop_front();
          if (skip_vals) chk("pair_last", 32'(got.l), 32'(e.l));
          else           chk("pair", 32'(got), 32'(e));
          if (!first_seen) first_got = got;
          first_seen = 1;
          last_got = got;
          rcv++;
        end
      end
      pstall = pair_valid_out && !pair_ready_in;
      pheld  = got;
    end
  end

  task automatic start_blk(int tx, int ty, int cx, int cy);
    @(posedge clk_in); #1;
    tmpl_x_in = 9'(tx); tmpl_y_in = 8'(ty);
    cand_x_in = 9'(cx); cand_y_in = 8'(cy);
    load_exp(tx, ty, cx, cy);
    rcv = 0; first_seen = 0;
    start_in = 1'b1;
    start_cyc = cyc;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    chk("busy_after_start", 32'(busy_out), 32'd1);
  endtask

  task automatic wait_done(bit chk_time);
    bit seen;
    seen = 0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk_in);
      if (done_out) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_out expected one within 1000 cycles");
    end else begin
      if (chk_time) chk("done_time", 32'(cyc - start_cyc), 32'(DONE_LAT));
      chk("pair_count", 32'(rcv), 32'(NP));
      chk("exp_left", 32'(exp_q.size()), 32'd0);
      chk("busy_in_done", 32'(busy_out), 32'd1);
      @(negedge clk_in);
      chk("done_pulse", 32'(done_out), 32'd0);
      chk("busy_after_done", 32'(busy_out), 32'd0);
    end
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_valid"}, 32'(pair_valid_out), 32'd0);
    chk({tag, "_last"},  32'(pair_last_out), 32'd0);
    chk({tag, "_tpix"},  32'(tmpl_pix_out), 32'd0);
    chk({tag, "_cpix"},  32'(cand_pix_out), 32'd0);
    chk({tag, "_busy"},  32'(busy_out), 32'd0);
    chk({tag, "_done"},  32'(done_out), 32'd0);
    chk({tag, "_taddr"}, 32'(tmpl_addr_out), 32'd0);
    chk({tag, "_caddr"}, 32'(cand_addr_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_in = 1'b1; start_in = 1'b0;
    tmpl_x_in = '0; tmpl_y_in = '0; cand_x_in = '0; cand_y_in = '0;
    repeat (3) @(negedge clk_in);
    chk_zero_outputs("reset");
    @(posedge clk_in); #1; rst_in = 1'b0;

    // 1: continuous ready, literal pins on first/last pair.
    rdy_mode = 0;
    start_blk(0, 0, 16, 2);
    wait_done(1);
    chk("t1_first_tmpl", 32'(first_got.t), 32'h00);
    chk("t1_first_cand", 32'(first_got.c), 32'h6F);
    chk("t1_last_tmpl",  32'(last_got.t),  32'hC7);
    chk("t1_last_cand",  32'(last_got.c),  32'hA8);
    chk("t1_last_flag",  32'(last_got.l),  32'd1);

    // 2: random backpressure, same block.
    rdy_mode = 1;
    start_blk(0, 0, 16, 2);
    wait_done(0);

    // 3: stall from start; issue must halt after FIFO_DEPTH reads.
    rdy_mode = 2;
    start_blk(5, 3, 100, 50);
    repeat (20) @(negedge clk_in);
    chk("t3_valid_stalled", 32'(pair_valid_out), 32'd1);
    chk("t3_tmpl_addr_halt", 32'(tmpl_addr_out), 32'(pix_addr(5, 3, L + 2)));
    chk("t3_cand_addr_halt", 32'(cand_addr_out), 32'(pix_addr(100, 50, L + 2)));
    chk("t3_rcv_zero", 32'(rcv), 32'd0);
    rdy_mode = 1;
    wait_done(0);

    // 4: restart attempt mid-block is ignored.
    rdy_mode = 0;
    start_blk(40, 20, 200, 100);
    repeat (20) @(negedge clk_in);
    @(posedge clk_in); #1;
    tmpl_x_in = 9'd77; tmpl_y_in = 8'd33; cand_x_in = 9'd12; cand_y_in = 8'd9;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    chk("t4_busy_kept", 32'(busy_out), 32'd1);
    wait_done(1);

    // 5: reset mid-block, then a clean block.
    rdy_mode = 1;
    start_blk(100, 60, 30, 40);
    seen = 0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk_in);
      if (rcv >= 30) seen = 1;
    end
    chk("t5_reached_30", 32'(seen), 32'd1);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    chk_zero_outputs("t5_rst");
    repeat (2) @(negedge clk_in);
    exp_q.delete();
    @(posedge clk_in); #1; rst_in = 1'b0;
    start_blk(100, 60, 30, 40);
    wait_done(0);

    // Random legal coordinates under random backpressure.
    for (int k = 0; k < 3; k++) begin
      rdy_mode = 1;
      start_blk(int'($urandom_range(0, W - BS)), int'($urandom_range(0, H - BS)),
                int'($urandom_range(0, W - BS)), int'($urandom_range(0, H - BS)));
      wait_done(0);
    end

    // 6: block overhanging the frame corner.
`ifdef SSD_STREAMER_CLAMP_EN
    skip_vals = 0;
`else
    skip_vals = 1;
`endif
    rdy_mode = 0;
    start_blk(316, 236, 10, 10);
    wait_done(1);
    skip_vals = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
